butterfly_stage_pipe: RTL and testbench

- Parametrised, pipelined first-stage butterfly for the forward transform datapath in tq.
- Transform size is selectable at runtime per row: 4, 8, 16 or 32 points.
- One output register stage with a valid/ready handshake, so it stalls cleanly under downstream backpressure.
- Sits between the residual/transpose row source and the partial-butterfly multiplier stages.

---
 rtl/butterfly_stage_pipe.sv | 102 ++++++++++
 tb/tb_butterfly_stage_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_stage_pipe.sv
// First-stage forward-transform butterfly (4/8/16/32 point) with one valid/ready output register.
// Optional row counter output o_row_cnt is built when BUTTERFLY_PERF_CNT_EN is defined.
module butterfly_stage_pipe #(
   parameter int IN_W  = 27,
   parameter int MAX_N = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [1:0]                    i_size,
   input  logic                          i_valid,
   output logic                          i_ready,
   input  logic [MAX_N*IN_W-1:0]         i_data,
   output logic                          o_valid,
   input  logic                          o_ready,
   output logic [1:0]                    o_size,
   output logic [MAX_N*(IN_W+1)-1:0]     o_data
`ifdef BUTTERFLY_PERF_CNT_EN
   ,
   output logic [15:0]                   o_row_cnt
`endif
);

   localparam int OUT_W = IN_W + 1;
   localparam logic [1:0] MAX_CODE = (MAX_N >= 32) ? 2'd3 :
                                     (MAX_N >= 16) ? 2'd2 :
                                     (MAX_N >= 8)  ? 2'd1 : 2'd0;

   logic                         r_valid;
   logic [1:0]                   r_size;
   logic [MAX_N*OUT_W-1:0]       r_data;

   logic                         w_accept;
   logic [1:0]                   w_eff_code;
   logic signed [OUT_W-1:0]      w_in  [MAX_N];
   logic [MAX_N*OUT_W-1:0]       w_result;

   assign i_ready    = !r_valid || o_ready;
   assign w_accept   = i_valid && i_ready;
   assign w_eff_code = (i_size > MAX_CODE) ? MAX_CODE : i_size;

   // Every candidate size is evaluated per lane with constant indices; the
   // runtime size code only steers a 4-way mux at the end of each lane.
   for (genvar k = 0; k < MAX_N; k++) begin : g_lane
      logic signed [OUT_W-1:0] w_cand [4];
      logic signed [OUT_W-1:0] w_out;

      assign w_in[k] = {i_data[k*IN_W + IN_W - 1], i_data[k*IN_W +: IN_W]};

      for (genvar c = 0; c < 4; c++) begin : g_code
         localparam int N = 4 << c;
         if (N <= MAX_N && k < N / 2) begin : g_sum
            assign w_cand[c] = w_in[k] + w_in[N-1-k];
         end else if (N <= MAX_N && k < N) begin : g_diff
            assign w_cand[c] = w_in[N-1-k] - w_in[k];
         end else begin : g_pass
            assign w_cand[c] = w_in[k];
         end
      end

      assign w_out = enable ? w_cand[w_eff_code] : w_in[k];
      assign w_result[k*OUT_W +: OUT_W] = w_out;
   end

   // NOTE: the wide data register is reset because its cleared value is
   // architecturally visible on o_data; it only loads on an accepted beat so
   // undriven input lanes between rows never reach it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_size  <= 2'd0;
         r_data  <= '0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b1;
            r_size  <= w_eff_code;
            r_data  <= w_result;
         end else if (o_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_size  = r_size;
   assign o_data  = r_data;

`ifdef BUTTERFLY_PERF_CNT_EN
   logic [15:0] r_row_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_cnt <= 16'd0;
      end else if (w_accept) begin
         r_row_cnt <= r_row_cnt + 16'd1;
      end
   end

   assign o_row_cnt = r_row_cnt;
`endif

endmodule

// File: tb/tb_butterfly_stage_pipe.sv
// Directed self-checking bench for butterfly_stage_pipe (32-lane instance plus an 8-lane clamp instance).
module tb_butterfly_stage_pipe;

   localparam int IN_W  = 27;
   localparam int OUT_W = IN_W + 1;
   localparam int MAX_N = 32;
   localparam int SM_N  = 8;

   logic                       clk;
   logic                       rst_n;
   logic                       enable;
   logic [1:0]                 i_size;
   logic                       i_valid;
   logic                       i_ready;
   logic [MAX_N*IN_W-1:0]      i_data;
   logic                       o_valid;
   logic                       o_ready;
   logic [1:0]                 o_size;
   logic [MAX_N*OUT_W-1:0]     o_data;

   logic                       i_ready_s;
   logic                       o_valid_s;
   logic [1:0]                 o_size_s;
   logic [SM_N*OUT_W-1:0]      o_data_s;

`ifdef BUTTERFLY_PERF_CNT_EN
   logic [15:0]                o_row_cnt;
   logic [15:0]                o_row_cnt_s;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   butterfly_stage_pipe #(.IN_W(IN_W), .MAX_N(MAX_N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .i_size    (i_size),
      .i_valid   (i_valid),
      .i_ready   (i_ready),
      .i_data    (i_data),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_size    (o_size),
      .o_data    (o_data)
`ifdef BUTTERFLY_PERF_CNT_EN
      ,
      .o_row_cnt (o_row_cnt)
`endif
   );

   butterfly_stage_pipe #(.IN_W(IN_W), .MAX_N(SM_N)) dut_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .i_size    (i_size),
      .i_valid   (i_valid),
      .i_ready   (i_ready_s),
      .i_data    (i_data[SM_N*IN_W-1:0]),
      .o_valid   (o_valid_s),
      .o_ready   (o_ready),
      .o_size    (o_size_s),
      .o_data    (o_data_s)
`ifdef BUTTERFLY_PERF_CNT_EN
      ,
      .o_row_cnt (o_row_cnt_s)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [OUT_W-1:0] lane(input int k);
      return o_data[k*OUT_W +: OUT_W];
   endfunction

   function automatic logic signed [OUT_W-1:0] lane_s(input int k);
      return o_data_s[k*OUT_W +: OUT_W];
   endfunction

   task automatic set_lane(input int k, input int v);
      i_data[k*IN_W +: IN_W] = v[IN_W-1:0];
   endtask

   task automatic set_ramp(input int offset);
      for (int k = 0; k < MAX_N; k++) set_lane(k, k + offset);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one row for exactly one clock edge with o_ready high.
   task automatic send(input logic en, input logic [1:0] sz);
      enable  = en;
      i_size  = sz;
      o_ready = 1'b1;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      enable  = 1'b0;
      i_size  = 2'd0;
      i_valid = 1'b0;
      o_ready = 1'b1;
      i_data  = '0;

      #2;
      check("rst_valid",  o_valid, 0);
      check("rst_size",   o_size, 0);
      check("rst_lane0",  lane(0), 0);
      check("rst_lane31", lane(31), 0);
      check("rst_ready",  i_ready, 1);
      #10 rst_n = 1'b1;

      // 32-point ramp
      set_ramp(0);
      send(1'b1, 2'd3);
      check("r32_valid",  o_valid, 1);
      check("r32_size",   o_size, 3);
      check("r32_o0",     lane(0), 31);
      check("r32_o15",    lane(15), 31);
      check("r32_o16",    lane(16), -1);
      check("r32_o17",    lane(17), -3);
      check("r32_o31",    lane(31), -31);
      check("clamp_size", o_size_s, 1);
      check("clamp_o0",   lane_s(0), 7);
      check("clamp_o4",   lane_s(4), -1);
      check("clamp_o7",   lane_s(7), -7);

      // drain with undriven input lanes
      i_data = 'x;
      tick();
      check("drain_valid", o_valid, 0);
      check("drain_hold0", lane(0), 31);
      check("drain_hold31", lane(31), -31);

      // 4-point sizing
      set_ramp(1);
      send(1'b1, 2'd0);
      check("r4_size", o_size, 0);
      check("r4_o0",   lane(0), 5);
      check("r4_o1",   lane(1), 5);
      check("r4_o2",   lane(2), -1);
      check("r4_o3",   lane(3), -3);
      check("r4_o4",   lane(4), 5);
      check("r4_o31",  lane(31), 32);

      // 8-point, back-to-back (accept while draining)
      check("b2b_ready", i_ready, 1);
      set_ramp(0);
      send(1'b1, 2'd1);
      check("r8_valid", o_valid, 1);
      check("r8_o0",    lane(0), 7);
      check("r8_o3",    lane(3), 7);
      check("r8_o4",    lane(4), -1);
      check("r8_o7",    lane(7), -7);
      check("r8_o8",    lane(8), 8);

      // 16-point
      send(1'b1, 2'd2);
      check("r16_size", o_size, 2);
      check("r16_o0",   lane(0), 15);
      check("r16_o7",   lane(7), 15);
      check("r16_o8",   lane(8), -1);
      check("r16_o15",  lane(15), -15);
      check("r16_o16",  lane(16), 16);

      // extremes
      for (int k = 0; k < MAX_N; k++) set_lane(k, -(1 << 26));
      send(1'b1, 2'd3);
      check("ext_o0",  lane(0), -(1 << 27));
      check("ext_o15", lane(15), -(1 << 27));
      check("ext_o16", lane(16), 0);
      check("ext_o31", lane(31), 0);

      tick();
      check("pre_bp_valid", o_valid, 0);

      // backpressure: rows A, B, C
      i_data = '0;
      set_lane(0, 100);
      send(1'b0, 2'd0);
      check("bp_a_valid", o_valid, 1);
      check("bp_a_lane0", lane(0), 100);
      set_lane(0, 200);
      i_valid = 1'b1;
      o_ready = 1'b0;
      #1;
      check("bp_stall_ready", i_ready, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("bp_hold_valid", o_valid, 1);
         check("bp_hold_lane0", lane(0), 100);
         check("bp_hold_ready", i_ready, 0);
      end
      o_ready = 1'b1;
      #1;
      check("bp_release_ready", i_ready, 1);
      tick();
      check("bp_b_lane0", lane(0), 200);
      check("bp_b_valid", o_valid, 1);
      set_lane(0, 300);
      tick();
      check("bp_c_lane0", lane(0), 300);
      i_valid = 1'b0;
      tick();
      check("bp_end_valid", o_valid, 0);
      check("bp_end_lane0", lane(0), 300);

      // bypass, then reset while stalled
      i_data = '0;
      set_lane(0, 7);
      set_lane(3, -5);
      enable  = 1'b0;
      i_size  = 2'd3;
      o_ready = 1'b0;
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      check("byp_valid", o_valid, 1);
      check("byp_o3",    lane(3), -5);
      check("byp_o0",    lane(0), 7);
      check("byp_size",  o_size, 3);
      tick();
      check("byp_hold_o3", lane(3), -5);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", o_valid, 0);
      check("arst_o3",    lane(3), 0);
      check("arst_o0",    lane(0), 0);
      check("arst_size",  o_size, 0);
      check("arst_ready", i_ready, 1);

`ifdef BUTTERFLY_PERF_CNT_EN
      check("cnt_rst", o_row_cnt, 0);
      #2 rst_n = 1'b1;
      i_valid = 1'b1;
      o_ready = 1'b0;
      tick();
      check("cnt_first", o_row_cnt, 1);
      tick();
      tick();
      tick();
      check("cnt_stall", o_row_cnt, 1);
      o_ready = 1'b1;
      repeat (65536) @(posedge clk);
      #1;
      check("cnt_wrap",  o_row_cnt, 1);
      check("cnt_valid", o_valid, 1);
      i_valid = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
